// File: rtl/axi_aw_arb_pkg.sv
// Shared types, field widths and helpers for the AXI AW round-robin arbiter.
package axi_aw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1
    } arb_state_e;

    localparam int PROT_W   = 3;
    localparam int REGION_W = 4;
    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 1;
    localparam int CACHE_W  = 4;
    localparam int QOS_W    = 4;

    // Fixed-width AW fields carried alongside addr/id/user.
    localparam int AW_FIXED_BITS = PROT_W + REGION_W + LEN_W + SIZE_W + BURST_W +
                                   LOCK_W + CACHE_W + QOS_W;

    // Explicit modulo so the port count need not be a power of two.
    function automatic int next_rr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr, wrapping.
module axi_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : p_pick
        int best;
        int off;
        best = N;
        off  = 0;
        idx  = '0;
        // Distance from the pointer decides priority; smallest distance wins.
        for (int i = 0; i < N; i++) begin
            off = (i >= int'(rr)) ? i - int'(rr) : i + N - int'(rr);
            if (req[i] && off < best) begin
                best = off;
                idx  = IDX_W'(i);
            end
        end
        any   = |req;
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/axi_aw_rr_arbiter.sv
// N-way round-robin arbiter sharing one AXI4 AW channel; grant held until handshake.
// Define AXI_AW_ARB_OUT_REG_EN to add a registered output stage after the mux.
module axi_aw_rr_arbiter
    import axi_aw_arb_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  ID_WIDTH   = 4,
    parameter int  ADDR_WIDTH = 32,
    parameter int  USER_WIDTH = 6,
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_PORTS-1:0]            slave_valid_i,
    output logic [NUM_PORTS-1:0]            slave_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] slave_addr_i,
    input  logic [NUM_PORTS*PROT_W-1:0]     slave_prot_i,
    input  logic [NUM_PORTS*REGION_W-1:0]   slave_region_i,
    input  logic [NUM_PORTS*LEN_W-1:0]      slave_len_i,
    input  logic [NUM_PORTS*SIZE_W-1:0]     slave_size_i,
    input  logic [NUM_PORTS*BURST_W-1:0]    slave_burst_i,
    input  logic [NUM_PORTS*LOCK_W-1:0]     slave_lock_i,
    input  logic [NUM_PORTS*CACHE_W-1:0]    slave_cache_i,
    input  logic [NUM_PORTS*QOS_W-1:0]      slave_qos_i,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]   slave_id_i,
    input  logic [NUM_PORTS*USER_WIDTH-1:0] slave_user_i,
    output logic                            master_valid_o,
    output logic [ADDR_WIDTH-1:0]           master_addr_o,
    output logic [PROT_W-1:0]               master_prot_o,
    output logic [REGION_W-1:0]             master_region_o,
    output logic [LEN_W-1:0]                master_len_o,
    output logic [SIZE_W-1:0]               master_size_o,
    output logic [BURST_W-1:0]              master_burst_o,
    output logic [LOCK_W-1:0]               master_lock_o,
    output logic [CACHE_W-1:0]              master_cache_o,
    output logic [QOS_W-1:0]                master_qos_o,
    output logic [ID_WIDTH-1:0]             master_id_o,
    output logic [USER_WIDTH-1:0]           master_user_o,
    output logic [IDX_W-1:0]                master_src_o,
    input  logic                            master_ready_i
);

    localparam int AW_W = ADDR_WIDTH + AW_FIXED_BITS + ID_WIDTH + USER_WIDTH;

    logic [NUM_PORTS-1:0][AW_W-1:0] beats;
    logic [AW_W-1:0]                out_beat;
    logic [IDX_W-1:0]               out_src;
    logic                           out_vld;
    logic [NUM_PORTS-1:0]           out_ready;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pack
        assign beats[i] = {slave_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH],
                           slave_prot_i[i*PROT_W +: PROT_W],
                           slave_region_i[i*REGION_W +: REGION_W],
                           slave_len_i[i*LEN_W +: LEN_W],
                           slave_size_i[i*SIZE_W +: SIZE_W],
                           slave_burst_i[i*BURST_W +: BURST_W],
                           slave_lock_i[i*LOCK_W +: LOCK_W],
                           slave_cache_i[i*CACHE_W +: CACHE_W],
                           slave_qos_i[i*QOS_W +: QOS_W],
                           slave_id_i[i*ID_WIDTH +: ID_WIDTH],
                           slave_user_i[i*USER_WIDTH +: USER_WIDTH]};
    end

`ifdef AXI_AW_ARB_OUT_REG_EN
    logic [IDX_W-1:0]     rr_q, win_idx, src_q;
    logic [NUM_PORTS-1:0] grant;
    logic                 any, load, vld_q;
    logic [AW_W-1:0]      beat_q;

    axi_rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
        .req   (slave_valid_i),
        .rr    (rr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (any)
    );

    // Capture into the output register is the upstream handshake.
    assign load = !vld_q || master_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            vld_q  <= 1'b0;
            beat_q <= '0;
            src_q  <= '0;
        end else if (load) begin
            vld_q  <= any;
            beat_q <= beats[win_idx];
            src_q  <= win_idx;
            if (any) rr_q <= IDX_W'(next_rr(int'(win_idx), NUM_PORTS));
        end
    end

    assign out_vld   = vld_q;
    assign out_beat  = beat_q;
    assign out_src   = src_q;
    assign out_ready = load ? grant : '0;
`else
    if (NUM_PORTS == 1) begin : g_pass
        assign out_vld   = slave_valid_i[0];
        assign out_beat  = beats[0];
        assign out_src   = '0;
        assign out_ready = {NUM_PORTS{master_ready_i}};
    end else begin : g_arb
        arb_state_e           state_q, state_d;
        logic [IDX_W-1:0]     rr_q, rr_d, lock_q, lock_d, sel, win_idx;
        logic [NUM_PORTS-1:0] grant, ready;
        logic                 any, vld;

        axi_rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
            .req   (slave_valid_i),
            .rr    (rr_q),
            .grant (grant),
            .idx   (win_idx),
            .any   (any)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                rr_q    <= '0;
                lock_q  <= '0;
            end else begin
                state_q <= state_d;
                rr_q    <= rr_d;
                lock_q  <= lock_d;
            end
        end

        always_comb begin
            state_d = state_q;
            rr_d    = rr_q;
            lock_d  = lock_q;
            sel     = win_idx;
            vld     = any;
            ready   = '0;
            case (state_q)
                IDLE: begin
                    if (any) begin
                        if (master_ready_i) begin
                            ready = grant;
                            rr_d  = IDX_W'(next_rr(int'(win_idx), NUM_PORTS));
                        end else begin
                            lock_d  = win_idx;
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Payload must stay stable until accepted; new requests wait.
                    sel           = lock_q;
                    vld           = slave_valid_i[lock_q];
                    ready[lock_q] = master_ready_i;
                    if (vld && master_ready_i) begin
                        rr_d    = IDX_W'(next_rr(int'(lock_q), NUM_PORTS));
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign out_vld   = vld;
        assign out_beat  = beats[sel];
        assign out_src   = sel;
        assign out_ready = ready;

        a_lock_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (state_q == LOCKED) |-> slave_valid_i[lock_q]);
        a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
            $onehot0(slave_ready_o));
    end
`endif

    // Handshake outputs are forced quiet while reset is asserted.
    assign master_valid_o = rst_ni & out_vld;
    assign slave_ready_o  = rst_ni ? out_ready : '0;
    assign master_src_o   = rst_ni ? out_src : '0;

    assign {master_addr_o, master_prot_o, master_region_o, master_len_o, master_size_o,
            master_burst_o, master_lock_o, master_cache_o, master_qos_o, master_id_o,
            master_user_o} = out_beat;

endmodule
